// File: rtl/operand_fwd_ctrl_pkg.sv
// Shared types, select codes and match helpers for the EX operand forwarding controller.
// FWD_WB_HOLD_EN selects whether a WB-stage producer is forwarded from the post-WB hold register.
package operand_fwd_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [1:0] FWD_SEL_RF    = 2'b00;
  localparam logic [1:0] FWD_SEL_EXMEM = 2'b01;
  localparam logic [1:0] FWD_SEL_MEMWB = 2'b10;
  localparam logic [1:0] FWD_SEL_PWB   = 2'b11;

`ifdef FWD_WB_HOLD_EN
  localparam logic [1:0] WbSel = FWD_SEL_PWB;
`else
  // Without the hold register the regfile is write-through, so WB producers read as regfile data.
  localparam logic [1:0] WbSel = FWD_SEL_RF;
`endif

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StLuStall = 2'b01,
    StMdBusy  = 2'b10
  } fwd_state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  load;
    logic                  md;
  } fwd_entry_t;

  function automatic logic fwd_match(input fwd_entry_t e, input logic [REG_ADDR_W-1:0] rs,
                                     input logic used);
    return e.valid & e.we & (e.rd == rs) & (rs != '0) & used;
  endfunction

  // Youngest producer wins; entries are sampled before the ID instruction moves into EX.
  function automatic logic [1:0] fwd_sel(input fwd_entry_t ex, input fwd_entry_t mem,
                                         input fwd_entry_t wb, input logic [REG_ADDR_W-1:0] rs,
                                         input logic used);
    if (fwd_match(ex, rs, used))  return FWD_SEL_EXMEM;
    if (fwd_match(mem, rs, used)) return FWD_SEL_MEMWB;
    if (fwd_match(wb, rs, used))  return WbSel;
    return FWD_SEL_RF;
  endfunction

endpackage

// File: rtl/operand_fwd_ctrl_track_entry.sv
// One pipeline tracker slot: holds valid/rd/we/load/md of an in-flight instruction.
module operand_fwd_ctrl_track_entry
  import operand_fwd_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       advance,
  input  logic       bubble,
  input  fwd_entry_t d,
  output fwd_entry_t q
);

  fwd_entry_t entry_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      entry_q <= '0;
    end else if (bubble) begin
      entry_q <= '0;
    end else if (advance) begin
      entry_q <= d;
    end
  end

  assign q = entry_q;

endmodule

// File: rtl/operand_fwd_ctrl.sv
// EX operand mux select generator with load-use and muldiv-busy stall control.
// Define FWD_WB_HOLD_EN to add the post-WB tracker slot and issue select code 11.
module operand_fwd_ctrl
  import operand_fwd_ctrl_pkg::*;
#(
  parameter int unsigned MD_MAX_CYC = 34
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  id_is_muldiv,
  input  logic                  md_done,
  input  logic                  flush,
  output logic [1:0]            ex_sel1,
  output logic [1:0]            ex_sel2,
  output logic                  stall,
  output logic                  md_timeout
);

  localparam int unsigned CntW = $clog2(MD_MAX_CYC + 1);

  fwd_entry_t      id_entry, ex_q, mem_q, wb_q;
  fwd_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_d, md_timeout_q;
  logic [1:0]      sel1_d, sel2_d, ex_sel1_q, ex_sel2_q;
  logic            lu_hazard, md_hazard, transfer;
  logic            unused_bits;

  always_comb begin
    id_entry = '{valid: id_valid, rd: id_rd, we: id_reg_write, load: id_is_load,
                 md: id_is_muldiv};
  end

  assign lu_hazard = id_valid & ex_q.load &
                     (fwd_match(ex_q, id_rs1, id_rs1_used) | fwd_match(ex_q, id_rs2, id_rs2_used));
  assign md_hazard = ex_q.valid & ex_q.md;
  assign stall     = ~flush & ((state_q == StMdBusy) | md_hazard | lu_hazard);
  assign transfer  = id_valid & ~stall & ~flush;

  operand_fwd_ctrl_track_entry u_ex (
    .CLK     (CLK),
    .RESET   (RESET),
    .advance (1'b1),
    .bubble  (~transfer),
    .d       (id_entry),
    .q       (ex_q)
  );

  operand_fwd_ctrl_track_entry u_mem (
    .CLK     (CLK),
    .RESET   (RESET),
    .advance (1'b1),
    .bubble  (1'b0),
    .d       (ex_q),
    .q       (mem_q)
  );

  operand_fwd_ctrl_track_entry u_wb (
    .CLK     (CLK),
    .RESET   (RESET),
    .advance (1'b1),
    .bubble  (1'b0),
    .d       (mem_q),
    .q       (wb_q)
  );

`ifdef FWD_WB_HOLD_EN
  fwd_entry_t pwb_q;

  operand_fwd_ctrl_track_entry u_pwb (
    .CLK     (CLK),
    .RESET   (RESET),
    .advance (1'b1),
    .bubble  (1'b0),
    .d       (wb_q),
    .q       (pwb_q)
  );

  // Slot mirrors the hold register's lifetime; its contents are never compared.
  assign unused_bits = ^pwb_q;
`else
  assign unused_bits = ^{wb_q.load, wb_q.md};
`endif

  always_comb begin
    sel1_d = FWD_SEL_RF;
    sel2_d = FWD_SEL_RF;
    if (transfer) begin
      sel1_d = fwd_sel(ex_q, mem_q, wb_q, id_rs1, id_rs1_used);
      sel2_d = fwd_sel(ex_q, mem_q, wb_q, id_rs2, id_rs2_used);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StMdBusy: begin
          if (md_done) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == CntW'(MD_MAX_CYC - 1)) begin
            state_d   = StIdle;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          // Muldiv busy takes precedence; a pending load-use is seen again once it clears.
          if (md_hazard) begin
            state_d = StMdBusy;
            cnt_d   = '0;
          end else if (lu_hazard) begin
            state_d = StLuStall;
          end else begin
            state_d = StIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      md_timeout_q <= 1'b0;
      ex_sel1_q    <= FWD_SEL_RF;
      ex_sel2_q    <= FWD_SEL_RF;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      md_timeout_q <= timeout_d;
      ex_sel1_q    <= sel1_d;
      ex_sel2_q    <= sel2_d;
    end
  end

  assign ex_sel1    = ex_sel1_q;
  assign ex_sel2    = ex_sel2_q;
  assign md_timeout = md_timeout_q;

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Scoreboard bench for operand_fwd_ctrl: a history-based reference model predicts every cycle.
module tb_operand_fwd_ctrl;

  localparam int MdMaxCyc = 34;

  typedef struct {
    bit valid;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
    int rd;
    bit we;
    bit ld;
    bit md;
  } instr_t;

  typedef struct {
    int sel1;
    int sel2;
    bit stall;
    bit to;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load, id_is_muldiv;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       md_done, flush;
  logic [1:0] ex_sel1, ex_sel2;
  logic       stall, md_timeout;

  operand_fwd_ctrl #(.MD_MAX_CYC(MdMaxCyc)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .id_is_muldiv (id_is_muldiv),
    .md_done      (md_done),
    .flush        (flush),
    .ex_sel1      (ex_sel1),
    .ex_sel2      (ex_sel2),
    .stall        (stall),
    .md_timeout   (md_timeout)
  );

  always #5 CLK = ~CLK;

  // Reference model: hist[k] is the instruction that entered EX k cycles ago (0 = now in EX).
  instr_t hist[$];
  instr_t bub;
  bit     m_busy, m_to;
  int     m_cnt, m_sel1, m_sel2;
  int     md_lat;  // busy cycles until md_done is pulsed; 0 = never
  exp_t   expq[$];
  int     checks, errors;

  function automatic instr_t mk(int rd, int rs1, int rs2, bit u1, bit u2, bit we, bit ld, bit md);
    instr_t i;
    i = '{valid: 1'b1, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, we: we, ld: ld, md: md};
    return i;
  endfunction

  // Select code = distance to youngest producer still in flight.
  function automatic int fwd_code(int rs, bit used);
    if (!used || rs == 0) return 0;
    for (int k = 0; k < 3; k++) begin
      if (hist[k].valid && hist[k].we && hist[k].rd == rs) begin
`ifdef FWD_WB_HOLD_EN
        return k + 1;
`else
        return (k == 2) ? 0 : k + 1;
`endif
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back(bub);
    m_busy = 1'b0;
    m_cnt  = 0;
    m_sel1 = 0;
    m_sel2 = 0;
    m_to   = 1'b0;
  endtask

  task automatic step(input instr_t ins, input bit fl, input bit rst, output bit stalled);
    instr_t ex;
    exp_t   e;
    bit     lu, mdh, st, xfer, done;
    @(posedge CLK);
    #1;
    ex   = hist[0];
    done = m_busy ? (md_lat != 0 && m_cnt + 1 == md_lat) : ($urandom_range(0, 15) == 0);
    RESET        = rst;
    flush        = fl;
    md_done      = done;
    id_valid     = ins.valid;
    id_rs1       = 5'(ins.rs1);
    id_rs2       = 5'(ins.rs2);
    id_rs1_used  = ins.u1;
    id_rs2_used  = ins.u2;
    id_rd        = 5'(ins.rd);
    id_reg_write = ins.we;
    id_is_load   = ins.ld;
    id_is_muldiv = ins.md;
    if (rst) begin
      model_reset();
      stalled = 1'b0;
      return;
    end
    lu  = ins.valid && ex.valid && ex.ld && ex.we && ex.rd != 0 &&
          ((ins.u1 && ins.rs1 == ex.rd) || (ins.u2 && ins.rs2 == ex.rd));
    mdh = ex.valid && ex.md;
    st  = !fl && (m_busy || mdh || lu);
    stalled = st;
    e = '{sel1: m_sel1, sel2: m_sel2, stall: st, to: m_to};
    expq.push_back(e);
    xfer = ins.valid && !st && !fl;
    m_to = 1'b0;
    if (fl) begin
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (m_busy) begin
      if (done) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end else if (m_cnt + 1 == MdMaxCyc) begin
        m_busy = 1'b0;
        m_cnt  = 0;
        m_to   = 1'b1;
      end else begin
        m_cnt++;
      end
    end else if (mdh) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end
    m_sel1 = xfer ? fwd_code(ins.rs1, ins.u1) : 0;
    m_sel2 = xfer ? fwd_code(ins.rs2, ins.u2) : 0;
    hist.push_front(xfer ? ins : bub);
    void'(hist.pop_back());
  endtask

  // Hold the instruction in ID until it leaves (transfer, flush, or invalid slot).
  task automatic issue(input instr_t ins, input bit fl);
    bit st;
    int n;
    n = 0;
    do begin
      step(ins, fl && n == 0, 1'b0, st);
      n++;
    end while (st && n < 200);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ex_sel1", int'(ex_sel1), e.sel1);
        chk("ex_sel2", int'(ex_sel2), e.sel2);
        chk("stall", int'(stall), int'(e.stall));
        chk("md_timeout", int'(md_timeout), int'(e.to));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin : stimulus
    instr_t nop, use3, ins;
    bit     st;
    checks = 0;
    errors = 0;
    bub    = '{default: 0};
    nop    = mk(0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    use3   = mk(4, 3, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    md_lat = 0;
    RESET = 1'b1; flush = 1'b0; md_done = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_rd = '0; id_reg_write = 1'b0; id_is_load = 1'b0; id_is_muldiv = 1'b0;
    model_reset();
    step(bub, 1'b0, 1'b1, st);
    step(bub, 1'b0, 1'b1, st);

    // Back-to-back dependency
    issue(mk(5, 1, 2, 1, 1, 1, 0, 0), 1'b0);
    issue(mk(6, 5, 5, 1, 1, 1, 0, 0), 1'b0);
    repeat (3) issue(nop, 1'b0);
    // One and two NOPs between producer and consumer
    issue(mk(5, 1, 2, 1, 1, 1, 0, 0), 1'b0);
    issue(nop, 1'b0);
    issue(mk(7, 5, 1, 1, 1, 1, 0, 0), 1'b0);
    repeat (3) issue(nop, 1'b0);
    issue(mk(5, 1, 2, 1, 1, 1, 0, 0), 1'b0);
    repeat (2) issue(nop, 1'b0);
    issue(mk(7, 5, 1, 1, 1, 1, 0, 0), 1'b0);
    repeat (3) issue(nop, 1'b0);
    // Load-use
    issue(mk(8, 1, 0, 1, 0, 1, 1, 0), 1'b0);
    issue(mk(9, 8, 0, 1, 1, 1, 0, 0), 1'b0);
    repeat (3) issue(nop, 1'b0);
    // x0 is never forwarded
    issue(mk(0, 0, 0, 1, 0, 1, 0, 0), 1'b0);
    issue(mk(1, 0, 0, 1, 1, 1, 0, 0), 1'b0);
    repeat (3) issue(nop, 1'b0);
    // Muldiv completing, then timing out
    md_lat = 9;
    issue(mk(3, 1, 2, 1, 1, 1, 0, 1), 1'b0);
    issue(use3, 1'b0);
    repeat (3) issue(nop, 1'b0);
    md_lat = 0;
    issue(mk(3, 1, 2, 1, 1, 1, 0, 1), 1'b0);
    issue(use3, 1'b0);
    repeat (3) issue(nop, 1'b0);
    // Reset while muldiv busy
    issue(mk(3, 1, 2, 1, 1, 1, 0, 1), 1'b0);
    repeat (5) step(use3, 1'b0, 1'b0, st);
    step(use3, 1'b0, 1'b1, st);
    issue(use3, 1'b0);
    repeat (3) issue(nop, 1'b0);
    // Flush during a load-use stall
    issue(mk(8, 1, 0, 1, 0, 1, 1, 0), 1'b0);
    issue(mk(9, 8, 0, 1, 1, 1, 0, 0), 1'b1);
    repeat (3) issue(nop, 1'b0);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        step(bub, 1'b0, 1'b1, st);
      end else begin
        ins = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 19) == 0);
        ins.valid = $urandom_range(0, 9) != 0;
        if (ins.md) md_lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
        issue(ins, $urandom_range(0, 19) == 0);
      end
    end
    repeat (3) issue(nop, 1'b0);
    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
